// File: rtl/mcu_dmi_arb_pkg.sv
// Shared types for the core-side DMI arbiter: FSM states, transaction owner
// and the buffered DMI command.
package mcu_dmi_arb_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_JTAG = 1'b0,
    OWN_SEC  = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] wdata;
  } dmi_cmd_t;

endpackage

// File: rtl/mcu_dmi_req_hold.sv
// One-entry holding register for JTAG DMI commands; a push while full and
// not being drained is dropped and flagged as a sticky overflow.
module mcu_dmi_req_hold
  import mcu_dmi_arb_pkg::*;
#(
  parameter type cmd_t = dmi_cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic push_i,
  input  cmd_t push_cmd_i,
  input  logic grant_i,
  output logic valid_o,
  output cmd_t cmd_o,
  output logic overflow_o
);

  logic valid_q, valid_d;
  cmd_t cmd_q, cmd_d;
  logic ovf_q, ovf_d;

  // A grant frees the slot in the same cycle, so a simultaneous push refills it.
  always_comb begin
    valid_d = valid_q;
    cmd_d   = cmd_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (grant_i) valid_d = 1'b0;
      if (push_i) begin
        if (!valid_q || grant_i) begin
          valid_d = 1'b1;
          cmd_d   = push_cmd_i;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign cmd_o      = cmd_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/mcu_dmi_arbiter.sv
// Shares the core's single DMI register port between the JTAG DMI path and a
// secondary SoC debug requester, one transaction at a time.
module mcu_dmi_arbiter
  import mcu_dmi_arb_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              core_clk,
  input  logic              core_rst_n,
  input  logic              dmi_hard_reset,
  input  logic              jtag_reg_en,
  input  logic              jtag_reg_wr_en,
  input  logic [ADDR_W-1:0] jtag_reg_addr,
  input  logic [DATA_W-1:0] jtag_reg_wr_data,
  output logic [DATA_W-1:0] jtag_rd_data,
  output logic              jtag_overflow,
  input  logic              sec_req_valid,
  output logic              sec_req_ready,
  input  logic              sec_req_we,
  input  logic [ADDR_W-1:0] sec_req_addr,
  input  logic [DATA_W-1:0] sec_req_wdata,
  output logic              sec_rsp_valid,
  output logic [DATA_W-1:0] sec_rsp_rdata,
  output logic              dmi_reg_en,
  output logic              dmi_reg_wr_en,
  output logic [ADDR_W-1:0] dmi_reg_addr,
  output logic [DATA_W-1:0] dmi_reg_wdata,
  input  logic [DATA_W-1:0] dmi_reg_rdata
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  logic [2:0]        lat_cnt_q;
  logic [3:0]        starve_q, starve_d;
  logic              dmi_en_q, dmi_we_q, rsp_valid_q;
  logic [ADDR_W-1:0] dmi_addr_q;
  logic [DATA_W-1:0] dmi_wdata_q, jtag_rd_q, sec_rd_q;

  logic hold_valid, hold_ovf;
  cmd_t hold_cmd, push_cmd;
  logic sec_starved, can_grant, grant_jtag, grant_sec;

  assign push_cmd = cmd_t'{we: jtag_reg_wr_en, addr: jtag_reg_addr, wdata: jtag_reg_wr_data};

  mcu_dmi_req_hold #(
    .cmd_t (cmd_t)
  ) u_hold (
    .clk        (core_clk),
    .rst_n      (core_rst_n),
    .clr_i      (dmi_hard_reset),
    .push_i     (jtag_reg_en),
    .push_cmd_i (push_cmd),
    .grant_i    (grant_jtag),
    .valid_o    (hold_valid),
    .cmd_o      (hold_cmd),
    .overflow_o (hold_ovf)
  );

  // Secondary is forced through once it has watched STARVE_MAX JTAG grants go by.
  assign sec_starved = sec_req_valid && (starve_q == 4'(STARVE_MAX));
  assign can_grant   = (state_q == IDLE) && !dmi_hard_reset;
  assign grant_jtag  = can_grant && hold_valid && !sec_starved;
  assign grant_sec   = can_grant && sec_req_valid && !grant_jtag;

  always_comb begin
    starve_d = starve_q;
    if (dmi_hard_reset || !sec_req_valid || grant_sec) begin
      starve_d = '0;
    end else if (grant_jtag && (starve_q != 4'(STARVE_MAX))) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_JTAG;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      dmi_en_q    <= 1'b0;
      dmi_we_q    <= 1'b0;
      dmi_addr_q  <= '0;
      dmi_wdata_q <= '0;
      jtag_rd_q   <= '0;
      sec_rd_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      dmi_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      starve_q    <= starve_d;
      if (dmi_hard_reset) begin
        state_q   <= IDLE;
        lat_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (grant_jtag || grant_sec) begin
              state_q  <= ISSUE;
              dmi_en_q <= 1'b1;
              if (grant_jtag) begin
                owner_q     <= OWN_JTAG;
                dmi_we_q    <= hold_cmd.we;
                dmi_addr_q  <= hold_cmd.addr;
                dmi_wdata_q <= hold_cmd.wdata;
              end else begin
                owner_q     <= OWN_SEC;
                dmi_we_q    <= sec_req_we;
                dmi_addr_q  <= sec_req_addr;
                dmi_wdata_q <= sec_req_wdata;
              end
            end
          end
          ISSUE: begin
            state_q   <= WAIT;
            lat_cnt_q <= 3'd1;
          end
          WAIT: begin
            // lat_cnt_q equals the number of cycles elapsed since the strobe.
            if (lat_cnt_q == 3'(RD_LAT)) begin
              state_q <= IDLE;
              if (!dmi_we_q) begin
                if (owner_q == OWN_JTAG) jtag_rd_q <= dmi_reg_rdata;
                else                     sec_rd_q  <= dmi_reg_rdata;
              end
              if (owner_q == OWN_SEC) rsp_valid_q <= 1'b1;
            end else begin
              lat_cnt_q <= lat_cnt_q + 3'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sec_req_ready = grant_sec;
  assign jtag_rd_data  = jtag_rd_q;
  assign jtag_overflow = hold_ovf;
  assign sec_rsp_valid = rsp_valid_q;
  assign sec_rsp_rdata = sec_rd_q;
  assign dmi_reg_en    = dmi_en_q;
  assign dmi_reg_wr_en = dmi_we_q;
  assign dmi_reg_addr  = dmi_addr_q;
  assign dmi_reg_wdata = dmi_wdata_q;

endmodule

// File: tb/tb_mcu_dmi_arbiter.sv
// Directed and randomized checks of mcu_dmi_arbiter against a timeline model
// of transaction occupancy, hold-slot occupancy and starvation counting.
module tb_mcu_dmi_arbiter;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic              hardReset = 1'b0;
  logic              jtagEn = 1'b0;
  logic              jtagWe = 1'b0;
  logic [ADDR_W-1:0] jtagAddr = '0;
  logic [DATA_W-1:0] jtagWdata = '0;
  logic [DATA_W-1:0] jtagRd;
  logic              jtagOverflow;
  logic              secValid = 1'b0;
  logic              secReady;
  logic              secWe = 1'b0;
  logic [ADDR_W-1:0] secAddr = '0;
  logic [DATA_W-1:0] secWdata = '0;
  logic              secRspValid;
  logic [DATA_W-1:0] secRdata;
  logic              dmiEn;
  logic              dmiWe;
  logic [ADDR_W-1:0] dmiAddr;
  logic [DATA_W-1:0] dmiWdata;
  logic [DATA_W-1:0] dmiRdata = '0;

  always #5 clk = ~clk;

  mcu_dmi_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .core_clk(clk), .core_rst_n(rstN), .dmi_hard_reset(hardReset),
    .jtag_reg_en(jtagEn), .jtag_reg_wr_en(jtagWe), .jtag_reg_addr(jtagAddr),
    .jtag_reg_wr_data(jtagWdata), .jtag_rd_data(jtagRd), .jtag_overflow(jtagOverflow),
    .sec_req_valid(secValid), .sec_req_ready(secReady), .sec_req_we(secWe),
    .sec_req_addr(secAddr), .sec_req_wdata(secWdata), .sec_rsp_valid(secRspValid),
    .sec_rsp_rdata(secRdata), .dmi_reg_en(dmiEn), .dmi_reg_wr_en(dmiWe),
    .dmi_reg_addr(dmiAddr), .dmi_reg_wdata(dmiWdata), .dmi_reg_rdata(dmiRdata)
  );

  int passCnt = 0;
  int checkCnt = 0;
  int cyc = 0;

  // Reference model: the port is busy from the grant edge through the sampling
  // cycle issueCyc+RD_LAT; the response pulse lands on the following cycle.
  bit                mHoldValid;
  bit                mHoldWe;
  logic [ADDR_W-1:0] mHoldAddr;
  logic [DATA_W-1:0] mHoldWdata;
  bit                mOvf;
  int                mStarve;
  bit                mBusy;
  int                mIssueCyc;
  bit                mOwnerSec;
  bit                mWe;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mWdata;
  logic [DATA_W-1:0] mJtagRd;
  logic [DATA_W-1:0] mSecRd;
  int                mRspCyc;

  task automatic modelReset();
    mHoldValid = 0; mHoldWe = 0; mHoldAddr = '0; mHoldWdata = '0;
    mOvf = 0; mStarve = 0; mBusy = 0; mIssueCyc = -1; mOwnerSec = 0;
    mWe = 0; mAddr = '0; mWdata = '0; mJtagRd = '0; mSecRd = '0; mRspCyc = -1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // One core cycle: compare all outputs with the model, advance the model,
  // cross the clock edge, then retire one-shot stimulus.
  task automatic applyStimulus();
    bit secStarved, gJ, gS, holdAtStart;
    #1;
    secStarved = secValid && (mStarve == STARVE_MAX);
    gJ = !hardReset && !mBusy && mHoldValid && !secStarved;
    gS = !hardReset && !mBusy && secValid && !gJ;
    checkOutput("dmi_reg_en", dmiEn, 32'(mBusy && (cyc == mIssueCyc)));
    checkOutput("dmi_reg_wr_en", dmiWe, 32'(mWe));
    checkOutput("dmi_reg_addr", dmiAddr, 32'(mAddr));
    checkOutput("dmi_reg_wdata", dmiWdata, mWdata);
    checkOutput("sec_rsp_valid", secRspValid, 32'(cyc == mRspCyc));
    checkOutput("sec_rsp_rdata", secRdata, mSecRd);
    checkOutput("jtag_rd_data", jtagRd, mJtagRd);
    checkOutput("jtag_overflow", jtagOverflow, 32'(mOvf));
    checkOutput("sec_req_ready", secReady, 32'(gS));
    if (hardReset) begin
      mBusy = 0; mHoldValid = 0; mStarve = 0; mOvf = 0;
    end else begin
      if (mBusy && (cyc == mIssueCyc + RD_LAT)) begin
        if (!mWe) begin
          if (mOwnerSec) mSecRd = dmiRdata;
          else           mJtagRd = dmiRdata;
        end
        if (mOwnerSec) mRspCyc = cyc + 1;
        mBusy = 0;
      end
      holdAtStart = mHoldValid;
      if (gJ || gS) begin
        mBusy = 1; mIssueCyc = cyc + 1; mOwnerSec = gS;
        if (gJ) begin
          mWe = mHoldWe; mAddr = mHoldAddr; mWdata = mHoldWdata; mHoldValid = 0;
        end else begin
          mWe = secWe; mAddr = secAddr; mWdata = secWdata;
        end
      end
      if (!secValid || gS) mStarve = 0;
      else if (gJ && mStarve < STARVE_MAX) mStarve++;
      if (jtagEn) begin
        if (!holdAtStart || gJ) begin
          mHoldValid = 1; mHoldWe = jtagWe; mHoldAddr = jtagAddr; mHoldWdata = jtagWdata;
        end else begin
          mOvf = 1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    jtagEn = 1'b0;
    if (gS) secValid = 1'b0;
  endtask

  initial begin
    int base;
    int jtagCount;
    bit secSeen;

    modelReset();
    #12;
    checkOutput("reset dmi_reg_en", dmiEn, 0);
    checkOutput("reset dmi_reg_addr", dmiAddr, 0);
    checkOutput("reset jtag_rd_data", jtagRd, 0);
    checkOutput("reset jtag_overflow", jtagOverflow, 0);
    checkOutput("reset sec_rsp_valid", secRspValid, 0);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] idle JTAG read");
    base = cyc;
    dmiRdata = 32'hDEADBEEF;
    jtagEn = 1; jtagWe = 0; jtagAddr = 7'h11;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      if (cyc == base + 2) begin
        checkOutput("t1 strobe", dmiEn, 1);
        checkOutput("t1 addr", dmiAddr, 32'h11);
        checkOutput("t1 wr_en", dmiWe, 0);
      end
      if (cyc == base + 4) checkOutput("t1 rdata", jtagRd, 32'hDEADBEEF);
      checkOutput("t1 no rsp", secRspValid, 0);
    end

    $display("[TB] secondary write");
    base = cyc;
    secValid = 1; secWe = 1; secAddr = 7'h10; secWdata = 32'h1;
    #1;
    checkOutput("t2 ready same cycle", secReady, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      if (cyc == base + 1) begin
        checkOutput("t2 strobe", dmiEn, 1);
        checkOutput("t2 wr_en", dmiWe, 1);
        checkOutput("t2 wdata", dmiWdata, 32'h1);
      end
      if (cyc == base + 3) begin
        checkOutput("t2 rsp pulse", secRspValid, 1);
        checkOutput("t2 rdata held", secRdata, 0);
      end
    end

    $display("[TB] contention");
    base = cyc;
    jtagEn = 1; jtagWe = 1; jtagAddr = 7'h20; jtagWdata = 32'h1234;
    applyStimulus();
    applyStimulus();
    jtagEn = 1; jtagWe = 0; jtagAddr = 7'h05;
    secValid = 1; secWe = 0; secAddr = 7'h06;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      if (cyc == base + 5) checkOutput("t3 jtag first", dmiAddr, 32'h05);
      if (cyc == base + 8) begin
        checkOutput("t3 sec next strobe", dmiEn, 1);
        checkOutput("t3 sec next addr", dmiAddr, 32'h06);
      end
    end

    $display("[TB] starvation");
    jtagEn = 1; jtagWe = 0; jtagAddr = 7'h40;
    applyStimulus();
    secValid = 1; secWe = 0; secAddr = 7'h30;
    jtagCount = 0;
    secSeen = 0;
    for (int i = 0; i < 80 && !secSeen; i++) begin
      if (!mHoldValid) begin
        jtagEn = 1; jtagAddr = 7'(8'h41 + i);
      end
      applyStimulus();
      if (dmiEn) begin
        if (dmiAddr == 7'h30) secSeen = 1;
        else jtagCount++;
      end
    end
    checkOutput("t4 sec granted", 32'(secSeen), 1);
    checkOutput("t4 jtag grants before sec", jtagCount, STARVE_MAX);
    for (int i = 0; i < 10; i++) applyStimulus();

    $display("[TB] overflow");
    secValid = 1; secWe = 0; secAddr = 7'h12; dmiRdata = 32'h0BADF00D;
    applyStimulus();
    jtagEn = 1; jtagAddr = 7'h13;
    applyStimulus();
    jtagEn = 1; jtagAddr = 7'h7F;
    applyStimulus();
    checkOutput("t5 overflow set", jtagOverflow, 1);
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("t5 overflow sticky", jtagOverflow, 1);

    $display("[TB] abort");
    secValid = 1; secWe = 0; secAddr = 7'h14; dmiRdata = 32'h5555AAAA;
    applyStimulus();
    applyStimulus();
    hardReset = 1;
    applyStimulus();
    hardReset = 0;
    checkOutput("t6 rsp suppressed", secRspValid, 0);
    checkOutput("t6 overflow cleared", jtagOverflow, 0);
    dmiRdata = 32'hCAFEF00D;
    jtagEn = 1; jtagWe = 0; jtagAddr = 7'h15;
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("t6 following read", jtagRd, 32'hCAFEF00D);

    $display("[TB] async reset mid-transaction");
    jtagEn = 1; jtagWe = 1; jtagAddr = 7'h22; jtagWdata = 32'hFFFF0000;
    applyStimulus();
    applyStimulus();
    rstN = 1'b0;
    #1;
    checkOutput("arst dmi_reg_en", dmiEn, 0);
    checkOutput("arst dmi_reg_addr", dmiAddr, 0);
    checkOutput("arst jtag_rd_data", jtagRd, 0);
    checkOutput("arst sec_rsp_rdata", secRdata, 0);
    modelReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      jtagEn    = ($urandom_range(0, 3) == 0);
      jtagWe    = 1'($urandom);
      jtagAddr  = 7'($urandom);
      jtagWdata = $urandom;
      if (!secValid && $urandom_range(0, 2) == 0) begin
        secValid = 1;
        secWe    = 1'($urandom);
        secAddr  = 7'($urandom);
        secWdata = $urandom;
      end
      hardReset = ($urandom_range(0, 63) == 0);
      dmiRdata  = $urandom;
      applyStimulus();
    end
    hardReset = 0;

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/mcu_dmi_arbiter.md
Name: mcu_dmi_arbiter

Overview:
- Core-clock-domain arbiter that shares the core's single DMI register port between two requesters:
  - the JTAG DMI path (single-cycle reg_en pulses from the JTAG-to-core synchronizer, no backpressure);
  - a secondary SoC-side debug requester (valid/ready).
- Buffers JTAG commands, sequences one DMI transaction at a time and returns read data to the owner.
- JTAG read data is held in a stable register for TAP sampling.
- Sits between the DMI wrapper and the core debug module.

Parameters:
- ADDR_W, 7, DMI register address width.
- DATA_W, 32, DMI data width.
- RD_LAT, 1, cycles from dmi_reg_en to valid dmi_reg_rdata (range 1-7).
- STARVE_MAX, 4, consecutive JTAG grants while secondary waits before secondary is forced to win (range 1-15).

Ports:
- core_clk  in  1  core clock
- core_rst_n  in  1  async active-low reset
- dmi_hard_reset  in  1  synchronous abort/clear, core domain
- jtag_reg_en  in  1  JTAG command pulse
- jtag_reg_wr_en  in  1  JTAG write qualifier, valid with jtag_reg_en
- jtag_reg_addr  in  ADDR_W  JTAG address
- jtag_reg_wr_data  in  DATA_W  JTAG write data
- jtag_rd_data  out  DATA_W  last JTAG read result, held
- jtag_overflow  out  1  sticky: JTAG command dropped
- sec_req_valid  in  1  secondary request valid
- sec_req_ready  out  1  secondary request accepted
- sec_req_we  in  1  secondary write
- sec_req_addr  in  ADDR_W  secondary address
- sec_req_wdata  in  DATA_W  secondary write data
- sec_rsp_valid  out  1  one-cycle response pulse
- sec_rsp_rdata  out  DATA_W  secondary read data, held
- dmi_reg_en  out  1  DMI access strobe to core
- dmi_reg_wr_en  out  1  DMI write enable
- dmi_reg_addr  out  ADDR_W  DMI address
- dmi_reg_wdata  out  DATA_W  DMI write data
- dmi_reg_rdata  in  DATA_W  DMI read data from core

Behaviour:
- Reset: all outputs 0; hold buffer empty; starve_cnt = 0; state IDLE.
- JTAG hold buffer (1 entry):
  - jtag_reg_en loads addr/we/wdata when the buffer is empty, or is being granted this cycle.
  - If the buffer is full and not granted, the command is dropped and jtag_overflow sets.
- Grant, evaluated in IDLE only:
  - JTAG wins if hold is valid, unless sec_req_valid && starve_cnt == STARVE_MAX.
  - Otherwise secondary wins if sec_req_valid.
- sec_req_ready = IDLE && secondary granted, combinational. Handshake occurs on valid && ready.
- starve_cnt:
  - increments on a JTAG grant while sec_req_valid;
  - clears on a secondary grant or when !sec_req_valid;
  - saturates at STARVE_MAX.
- FSM:
  - IDLE -> ISSUE on grant. The command is registered into dmi_reg_* outputs and the owner is latched.
  - ISSUE: dmi_reg_en = 1 for exactly one cycle (call it N); dmi_reg_wr_en/addr/wdata valid that cycle. Goes to WAIT.
  - WAIT: counts to RD_LAT. At the edge ending cycle N+RD_LAT, dmi_reg_rdata is sampled into the owner's data register if the access was a read. Goes to IDLE.
  - In cycle N+RD_LAT+1, for secondary ownership, sec_rsp_valid = 1 for one cycle; writes also pulse (ack) and leave sec_rsp_rdata unchanged.
  - jtag_rd_data updates only on JTAG reads and is otherwise held.
- Throughput:
  - earliest next ISSUE is N+RD_LAT+2;
  - JTAG latency from pulse to dmi_reg_en is 2 cycles when idle.
- dmi_reg_* outputs other than dmi_reg_en hold their last value; dmi_reg_en is 0 outside ISSUE.
- dmi_hard_reset, on the next edge:
  - state goes to IDLE; hold buffer, starve_cnt and jtag_overflow clear;
  - a pending sec_rsp_valid is suppressed; jtag_rd_data holds;
  - while it is asserted, sec_req_ready = 0 and JTAG pulses are ignored.
- Async reset mid-transaction: everything returns to reset values immediately.

Decomposition:
- Package mcu_dmi_arb_pkg: state enum (IDLE, ISSUE, WAIT), owner enum (OWN_JTAG, OWN_SEC), dmi_cmd_t struct (we, addr, wdata).
- Sub-module mcu_dmi_req_hold: one-entry JTAG holding register with load/grant/overflow logic.

Test Plan:
- Idle JTAG read: jtag_reg_en at cycle 0, addr 0x11, RD_LAT = 1, core returns 0xDEADBEEF -> dmi_reg_en at cycle 2 with addr 0x11, wr_en = 0; jtag_rd_data = 0xDEADBEEF from cycle 4; no sec_rsp_valid.
- Secondary write: sec_req_valid with addr 0x10, wdata 0x1 while idle -> ready same cycle, dmi_reg_en next cycle with wr_en = 1 and wdata 0x1; sec_rsp_valid pulse 2 cycles after dmi_reg_en; sec_rsp_rdata unchanged.
- Contention: JTAG pulse and sec_req_valid in the same cycle -> JTAG issued first, secondary issued at the next IDLE.
- Starvation: sec_req_valid held with a JTAG command refilled every transaction -> after 4 consecutive JTAG grants, secondary is granted; starve_cnt returns to 0.
- Overflow: two JTAG pulses while a secondary transaction is in flight -> first buffered, second dropped; jtag_overflow = 1 until dmi_hard_reset.
- Abort: dmi_hard_reset during WAIT of a secondary read -> no sec_rsp_valid; state IDLE next cycle; jtag_overflow = 0; a following JTAG read completes normally.
